// File: rtl/hazard_unit.sv
// Hazard unit: decode-stage stall/forward decisions from shadow copies of the
// D/E and E/M pipeline registers, plus a saturating stalled-cycle counter.
module hazard_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [5:0]  Tuse_D,
  input  logic [2:0]  Tnew_D,
  input  logic [4:0]  wr_D,
  output logic        stall_D,
  output logic        flush_E,
  output logic        fwd_rs_D,
  output logic        fwd_rt_D,
  output logic [1:0]  emf_sel,
  output logic [15:0] stall_cnt
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned TIME_W = 3;
  localparam int unsigned CNT_W  = 16;

  localparam logic [TIME_W-1:0] TUSE_NONE = 3'b111;
  localparam logic [1:0]        SEL_NONE  = 2'b00;
  localparam logic [1:0]        SEL_E     = 2'b01;
  localparam logic [1:0]        SEL_M     = 2'b10;
  localparam logic [CNT_W-1:0]  CNT_MAX   = 16'hFFFF;

  logic [REG_W-1:0]  e_wr, m_wr;
  logic [TIME_W-1:0] e_tnew, m_tnew;

  logic [3:0] res_rs, res_rt;
  logic       stall_rs, stall_rt, want_rs, want_rt;
  logic [1:0] stage_rs, stage_rt;
  logic       bus_conflict;

  // Resolve one source against the youngest matching stage.
  // Returns {stall, forward, stage[1:0]}.
  function automatic logic [3:0] resolve(
    input logic [REG_W-1:0]  addr,
    input logic [TIME_W-1:0] tuse,
    input logic [REG_W-1:0]  ewr,
    input logic [TIME_W-1:0] etn,
    input logic [REG_W-1:0]  mwr,
    input logic [TIME_W-1:0] mtn
  );
    logic              live;
    logic [TIME_W-1:0] tn;
    logic [1:0]        stg;
    logic              hit;
    live = (addr != '0) && (tuse != TUSE_NONE);
    hit  = 1'b0;
    tn   = '0;
    stg  = SEL_NONE;
    if (live && addr == ewr) begin
      hit = 1'b1;
      tn  = etn;
      stg = SEL_E;
    end else if (live && addr == mwr) begin
      hit = 1'b1;
      tn  = mtn;
      stg = SEL_M;
    end
    resolve = {hit && (tn > tuse), hit && (tn == '0), stg};
  endfunction

  // Zero-latency hazard decision from shadows and decode operands.
  always_comb begin
    res_rs       = resolve(rs_D, Tuse_D[5:3], e_wr, e_tnew, m_wr, m_tnew);
    res_rt       = resolve(rt_D, Tuse_D[2:0], e_wr, e_tnew, m_wr, m_tnew);
    stall_rs     = res_rs[3];
    want_rs      = res_rs[2];
    stage_rs     = res_rs[1:0];
    stall_rt     = res_rt[3];
    want_rt      = res_rt[2];
    stage_rt     = res_rt[1:0];
    bus_conflict = want_rs && want_rt && (stage_rs != stage_rt);

    stall_D  = stall_rs || stall_rt || bus_conflict;
    flush_E  = stall_D;
    fwd_rs_D = 1'b0;
    fwd_rt_D = 1'b0;
    emf_sel  = SEL_NONE;
    if (!stall_D) begin
      fwd_rs_D = want_rs;
      fwd_rt_D = want_rt;
      if (want_rs)      emf_sel = stage_rs;
      else if (want_rt) emf_sel = stage_rt;
    end
  end

  // Shadow pipeline advance; a stall inserts a bubble into E.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_wr   <= '0;
      e_tnew <= '0;
      m_wr   <= '0;
      m_tnew <= '0;
    end else begin
      m_wr   <= e_wr;
      m_tnew <= (e_tnew == '0) ? '0 : e_tnew - TIME_W'(1);
      if (stall_D) begin
        e_wr   <= '0;
        e_tnew <= '0;
      end else begin
        e_wr   <= wr_D;
        e_tnew <= Tnew_D;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_D && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, wr_D;
  logic [5:0]  Tuse_D;
  logic [2:0]  Tnew_D;
  logic        stall_D, flush_E, fwd_rs_D, fwd_rt_D;
  logic [1:0]  emf_sel;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_unit dut (
    .clk       (clk),
    .reset     (reset),
    .rs_D      (rs_D),
    .rt_D      (rt_D),
    .Tuse_D    (Tuse_D),
    .Tnew_D    (Tnew_D),
    .wr_D      (wr_D),
    .stall_D   (stall_D),
    .flush_E   (flush_E),
    .fwd_rs_D  (fwd_rs_D),
    .fwd_rt_D  (fwd_rt_D),
    .emf_sel   (emf_sel),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a decode instruction, then let combinational outputs settle.
  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [2:0] tu_rs, input logic [2:0] tu_rt,
                       input logic [2:0] tnew, input logic [4:0] wr);
    rs_D   = rs;
    rt_D   = rt;
    Tuse_D = {tu_rs, tu_rt};
    Tnew_D = tnew;
    wr_D   = wr;
    #1;
  endtask

  task automatic nop();
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 3'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic st, input logic frs,
                         input logic frt, input logic [1:0] sel);
    chk({tag, ".stall"},  32'(stall_D),  32'(st));
    chk({tag, ".flush"},  32'(flush_E),  32'(st));
    chk({tag, ".fwd_rs"}, 32'(fwd_rs_D), 32'(frs));
    chk({tag, ".fwd_rt"}, 32'(fwd_rt_D), 32'(frt));
    chk({tag, ".emf"},    32'(emf_sel),  32'(sel));
  endtask

  initial begin
    reset = 1'b1;
    nop();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 2'b00);
    chk("reset.cnt", 32'(stall_cnt), 32'd0);

    // lw $8 then beq $8: two stalls, then nothing to forward
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 3'd2, 5'd8);
    chk_out("lw.issue", 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    set_d(5'd8, 5'd0, 3'd0, 3'd7, 3'd0, 5'd0);
    chk_out("lw.stall1", 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    chk_out("lw.stall2", 1'b1, 1'b0, 1'b0, 2'b00);
    chk("lw.cnt1", 32'(stall_cnt), 32'd1);
    tick();
    chk_out("lw.go", 1'b0, 1'b0, 1'b0, 2'b00);
    chk("lw.cnt2", 32'(stall_cnt), 32'd2);
    tick();

    // addu $9 then beq $9: one stall then forward from M
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 3'd1, 5'd9);
    tick();
    set_d(5'd9, 5'd0, 3'd0, 3'd7, 3'd0, 5'd0);
    chk_out("addu_beq.stall", 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    chk_out("addu_beq.fwd", 1'b0, 1'b1, 1'b0, 2'b10);
    chk("addu_beq.cnt", 32'(stall_cnt), 32'd3);
    tick();

    // addu $9 then consumer with Tuse 1: no action; rt with Tuse 0 stalls
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 3'd1, 5'd9);
    tick();
    set_d(5'd9, 5'd0, 3'd1, 3'd7, 3'd1, 5'd10);
    chk_out("addu_addu", 1'b0, 1'b0, 1'b0, 2'b00);
    set_d(5'd0, 5'd9, 3'd7, 3'd0, 3'd0, 5'd0);
    chk_out("addu_rt0", 1'b1, 1'b0, 1'b0, 2'b00);
    nop();
    tick();
    tick();

    // rs needs E, rt needs M: bus conflict stall, then rs forwards from M
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 3'd1, 5'd10);
    tick();
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 3'd0, 5'd31);
    tick();
    set_d(5'd31, 5'd10, 3'd0, 3'd0, 3'd0, 5'd0);
    chk_out("jal.conflict", 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    chk_out("jal.resolve", 1'b0, 1'b1, 1'b0, 2'b10);
    chk("jal.cnt", 32'(stall_cnt), 32'd4);
    tick();

    // both sources forward from E
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 3'd0, 5'd12);
    tick();
    set_d(5'd12, 5'd12, 3'd0, 3'd0, 3'd0, 5'd0);
    chk_out("same_e", 1'b0, 1'b1, 1'b1, 2'b01);
    nop();
    tick();
    tick();

    // zero addresses with empty E; Tuse 7 ignored despite a pending write
    set_d(5'd0, 5'd0, 3'd0, 3'd0, 3'd0, 5'd0);
    chk_out("zero_src", 1'b0, 1'b0, 1'b0, 2'b00);
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 3'd3, 5'd12);
    tick();
    set_d(5'd12, 5'd12, 3'd7, 3'd7, 3'd0, 5'd0);
    chk_out("tuse7", 1'b0, 1'b0, 1'b0, 2'b00);
    nop();
    tick();
    tick();
    chk("idle.cnt", 32'(stall_cnt), 32'd4);

    // saturation: preload counter near the top, then two stalled edges
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 3'd7, 5'd8);
    tick();
    set_d(5'd8, 5'd0, 3'd0, 3'd7, 3'd0, 5'd0);
    force dut.stall_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    #1;
    chk("sat.pre", 32'(stall_cnt), 32'hFFFE);
    chk("sat.stall_a", 32'(stall_D), 32'd1);
    tick();
    chk("sat.top", 32'(stall_cnt), 32'hFFFF);
    chk("sat.stall_b", 32'(stall_D), 32'd1);
    tick();
    chk("sat.hold", 32'(stall_cnt), 32'hFFFF);
    chk("sat.stall_c", 32'(stall_D), 32'd0);
    nop();
    tick();

    // reset in the first lw stall cycle
    set_d(5'd0, 5'd0, 3'd7, 3'd7, 3'd2, 5'd8);
    tick();
    set_d(5'd8, 5'd0, 3'd0, 3'd7, 3'd0, 5'd0);
    chk("rst_mid.pre", 32'(stall_D), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 2'b00);
    chk("rst_mid.cnt", 32'(stall_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-002 SHALL provide port clk  in  1  rising-edge clock for all state.
REQ-003 SHALL provide port reset  in  1  synchronous active-high reset.
REQ-004 SHALL provide port rs_D  in  5  Instr[25:21] of the decode-stage instruction.
REQ-005 SHALL provide port rt_D  in  5  Instr[20:16] of the decode-stage instruction.
REQ-006 SHALL provide port Tuse_D  in  6  {Tuse_rs[2:0], Tuse_rt[2:0]} from decode; 3'b111 = operand unused.
REQ-007 SHALL provide port Tnew_D  in  3  cycles after E entry until the decode instruction's result is forwardable (0 = ready in E).
REQ-008 SHALL provide port wr_D  in  5  destination register of the decode instruction (0 = no write).
REQ-009 SHALL provide port stall_D  out  1  freeze PC and the F/D register.
REQ-010 SHALL provide port flush_E  out  1  load a bubble into the D/E register.
REQ-011 SHALL provide port fwd_rs_D  out  1  select the forward bus for decode rs.
REQ-012 SHALL provide port fwd_rt_D  out  1  select the forward bus for decode rt.
REQ-013 SHALL provide port emf_sel  out  2  forward-bus source: 00 none, 01 E result, 10 M result.
REQ-014 SHALL provide port stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-015 SHALL keep shadow entries E{wr,tnew} and M{wr,tnew} that mirror the D/E and E/M pipeline registers.
REQ-016 SHALL update the shadows each cycle without stall: E <= {wr_D, Tnew_D}; M <= {wr_E, sat0(tnew_E-1)}.
REQ-017 SHALL update the shadows on a stall cycle: E <= {0,0} (bubble); M <= {wr_E, sat0(tnew_E-1)}.
REQ-018 SHALL not track W: GRF write-before-read bypass covers the W stage.
REQ-019 SHALL, per source s in {rs,rt} with addr != 0 and Tuse != 7, use only the youngest matching stage (E over M).
REQ-020 SHALL stall for source s when the match has tnew > Tuse_s.
REQ-021 SHALL forward for source s from the matching stage when the match has tnew == 0.
REQ-022 SHALL neither stall nor forward for s when the match has 0 < tnew <= Tuse_s; downstream forwarding handles it.
REQ-023 SHALL ignore any source whose address is 0 or whose Tuse is 7, even if wr_E/wr_M is 0.
REQ-024 SHALL stall when rs and rt both need forwarding from different stages (single forward bus); fwd_rs_D, fwd_rt_D, emf_sel SHALL then be 0.
REQ-025 SHALL drive emf_sel with the common stage when both sources forward from the same stage, and assert both fwd flags.
REQ-026 SHALL make stall_D, flush_E, fwd_*, emf_sel combinational from current shadows and D inputs (zero latency); flush_E == stall_D.
REQ-027 SHALL force fwd_rs_D, fwd_rt_D and emf_sel to 0 whenever stall_D = 1.
REQ-028 SHALL increment stall_cnt on each clock edge with stall_D = 1, saturating at 16'hFFFF.

Reset
REQ-029 SHALL, on reset edge, clear E and M shadows to {0,0} and stall_cnt to 0, so stall_D = 0, flush_E = 0, emf_sel = 00 the cycle after.
REQ-030 SHALL give reset priority over stall updates, including reset asserted mid-stall.

Verification
REQ-031 SHALL cover: lw $8 (wr_D=8, Tnew_D=2), then beq $8 (rs_D=8, Tuse_rs=0) -> stall_D=1 for 2 cycles, then fwd none, stall_cnt=2.
REQ-032 SHALL cover: addu $9 (Tnew_D=1), then beq $9 -> 1 stall, next cycle fwd_rs_D=1, emf_sel=10.
REQ-033 SHALL cover: addu $9 (Tnew_D=1), then addu using $9 with Tuse_rs=1 -> stall_D=0, fwd_rs_D=0.
REQ-034 SHALL cover: jal wr=31 Tnew=0 in E, rs_D=31 and rt_D matches M with tnew 0 -> 1 stall, then forwarding resolves.
REQ-035 SHALL cover: rs_D=rt_D=0 with wr_E=0 -> stall_D=0, fwd flags 0; also stall_cnt held at 16'hFFFF under continuous stall.
REQ-036 SHALL cover: reset asserted in first lw stall cycle -> next cycle stall_D=0, stall_cnt=0.
